// File: rtl/vischain_pkg.sv
// rtl/vischain_pkg.sv - shared types and sizing helpers for the visibility readout chain
//
// Provides:
//   state_t      - drain FSM states (IDLE, DRAIN)
//   frame_words  - words per frame for a chain of a given length (2 per unit)
//   cnt_bits     - width of the word counter for a chain of a given length
package vischain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int frame_words(input int length);
    return 2 * length;
  endfunction

  function automatic int cnt_bits(input int length);
    return (2 * length > 1) ? $clog2(2 * length) : 1;
  endfunction

endpackage

// File: rtl/vischain_cell.sv
// rtl/vischain_cell.sv - one (re, im) register pair of the visibility readout chain
//
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   capture         load re_i/im_i into the pair
//   shift           advance one word toward the head: im -> re, next_re_i -> im
//   re_i, im_i      parallel capture values
//   next_re_i       re word of the following cell (zero at the tail)
//   head_o          word this cell presents toward the head (its re register)
module vischain_cell #(
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             capture,
  input  logic             shift,
  input  logic [WIDTH-1:0] re_i,
  input  logic [WIDTH-1:0] im_i,
  input  logic [WIDTH-1:0] next_re_i,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] re_q;
  logic [WIDTH-1:0] im_q;

  // Capture wins over shift: a reload on the last-word handshake replaces the frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (capture) begin
      re_q <= re_i;
      im_q <= im_i;
    end else if (shift) begin
      re_q <= im_q;
      im_q <= next_re_i;
    end
  end

  assign head_o = re_q;

endmodule

// File: rtl/vischain_drain.sv
// rtl/vischain_drain.sv - parallel-capture, word-serial drain of correlator visibilities
//
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   load_i          one-cycle strobe: capture every unit's re/im accumulators
//   re_i, im_i      packed accumulators, unit k at [k*WIDTH +: WIDTH]
//   valid_o         data_o holds a valid word
//   ready_i         downstream accepts the word when valid_o && ready_i
//   data_o          current word (frame order re0, im0, re1, im1, ...)
//   last_o          current word is the final word of the frame
//   busy_o          a frame is held and not yet fully accepted
//   overflow_o      sticky: a load arrived mid-frame and was dropped
module vischain_drain
  import vischain_pkg::*;
#(
  parameter int LENGTH = 3,
  parameter int WIDTH  = 7,
  parameter int CBITS  = cnt_bits(LENGTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load_i,
  input  logic [LENGTH*WIDTH-1:0] re_i,
  input  logic [LENGTH*WIDTH-1:0] im_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    overflow_o
);

  localparam logic [CBITS-1:0] LAST_CNT = CBITS'(frame_words(LENGTH) - 1);

  state_t           state;
  logic [CBITS-1:0] cnt;
  logic             overflow;

  logic             handshake;
  logic             at_last;
  logic             capture;
  logic             shift;
  logic             drop;

  logic [WIDTH-1:0] head    [LENGTH];
  logic [WIDTH-1:0] next_re [LENGTH];

  assign at_last   = (state == DRAIN) && (cnt == LAST_CNT);
  assign handshake = (state == DRAIN) && ready_i;
  // A load is only honoured when the chain is empty or is emptying this very cycle.
  assign capture   = load_i && ((state == IDLE) || (handshake && at_last));
  assign shift     = handshake && !capture;
  assign drop      = load_i && (state == DRAIN) && !(handshake && at_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (at_last) begin
              cnt <= '0;
              if (!load_i) state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  for (genvar k = 0; k < LENGTH; k++) begin : g_cell
    // The tail feeds zeros so a fully drained chain rests at zero.
    if (k == LENGTH - 1) begin : g_tail
      assign next_re[k] = '0;
    end else begin : g_link
      assign next_re[k] = head[k+1];
    end

    vischain_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clock    (clock),
      .reset_n  (reset_n),
      .capture  (capture),
      .shift    (shift),
      .re_i     (re_i[k*WIDTH +: WIDTH]),
      .im_i     (im_i[k*WIDTH +: WIDTH]),
      .next_re_i(next_re[k]),
      .head_o   (head[k])
    );
  end

  assign valid_o    = (state == DRAIN);
  assign busy_o     = (state == DRAIN);
  assign last_o     = at_last;
  assign data_o     = head[0];
  assign overflow_o = overflow;

endmodule
